muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle integer multiply/divide unit for the RV32M extension; successor to the
//  single-cycle combinational adder, adding operation modes, sign handling and a start/done handshake.
//  Sits beside the ALU in EX; the core stalls on busy and writes result to rd when done pulses.
//  Iterative: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per clock.
// PARAMETERS
//  XLEN  32  operand/result width in bits (>=8); iteration count = XLEN
// PORTS
//  clk     in   1     rising-edge clock
//  rst     in   1     asynchronous, active-high reset
//  start   in   1     request; sampled only in IDLE
//  kill    in   1     abort current operation (pipeline flush)
//  op      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a       in   XLEN  rs1 operand (multiplicand / dividend)
//  b       in   XLEN  rs2 operand (multiplier / divisor)
//  busy    out  1     high from the cycle after start is accepted until done
//  done    out  1     one-cycle pulse; result valid in that cycle
//  result  out  XLEN  final result; held stable until the next accepted start
// BEHAVIOUR
//  - Reset (any time, incl. mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs cleared.
//  - States: IDLE -> CALC -> FIX -> IDLE (done pulses on the FIX->IDLE edge).
//  - IDLE: start=1 at edge k latches op, |a|, |b|, result sign(s), counter=0; next state CALC (or FIX for special cases).
//  - CALC: one iteration per edge; after XLEN iterations (edge k+XLEN) -> FIX. Counter wraps never (saturates at XLEN-1).
//  - FIX: sign correction (two's-complement negate per op), select low/high half or quotient/remainder;
//    edge k+XLEN+1 registers result, done=1 for exactly one cycle, busy=0. Latency = XLEN+1 edges after acceptance.
//  - Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
//  - MUL returns low XLEN bits of 2*XLEN product; MULH* return high XLEN bits.
//  - REM sign follows dividend; DIV truncates toward zero.
//  - Special cases (bypass CALC, go IDLE->FIX, done at edge k+1):
//      divide-by-zero: DIV/DIVU -> all ones; REM/REMU -> a.
//      signed overflow (a=-2^(XLEN-1), b=-1): DIV -> a; REM -> 0.
//  - start while busy or in FIX: ignored, no effect on current op.
//  - kill: in CALC or FIX forces IDLE at next edge, busy=0, done stays 0, result unchanged;
//    kill and start together in IDLE: kill wins, start ignored.
//  - done and start same cycle: start accepted (unit already in IDLE in the done cycle? no — done is
//    asserted in the first IDLE cycle after FIX, so start in that cycle is accepted normally).
//  - Inputs a/b/op need only be valid in the start cycle.
// STRUCTURE
//  - muldiv_pkg: op encoding localparams (OP_MUL..OP_REMU), state enum (IDLE, CALC, FIX), XLEN default.
//  - One natural sub-module: muldiv_step (combinational single iteration: shift-add for multiply,
//    trial-subtract/restore for divide, 2*XLEN accumulator in/out); FSM, counter and sign fix in top.
// TESTING
//  - MUL a=7, b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, done exactly 33 edges after start edge, busy high between.
//  - MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF,b=2 -> 0xFFFFFFFF.
//  - DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  - DIV a=0x12345678, b=0 -> 0xFFFFFFFF, REM -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000,
//    REM -> 0; all with done at edge k+1.
//  - Start DIVU, assert kill after 10 cycles -> busy drops next edge, no done, result holds previous value;
//    new start afterwards completes normally.
//  - Assert rst asynchronously mid-CALC -> busy/done/result 0 immediately; start pulses while busy ignored
//    (result matches first operation only).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states and operand signedness helpers.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // rs1 is treated as signed for every op except the fully unsigned ones
    function automatic logic op_a_signed(input logic [2:0] op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    // rs2 is signed only for the signed x signed ops (MULHSU treats it unsigned)
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// trial-subtract for divide, over a 2*XLEN accumulator {hi, lo}.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the partial product
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]}
              + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // Divide: hi is the partial remainder, lo the dividend shifting into quotient
        trial = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
        if (!is_div) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else if (!trial[XLEN]) begin
            acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {acc_in[2*XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: magnitudes are iterated unsigned for
// XLEN cycles, then sign-corrected and the requested half is registered.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     operand_q, operand_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [CW-1:0]       count_q, count_d;
    logic                busy_d, done_d;
    logic [XLEN-1:0]     result_d;

    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [2*XLEN-1:0]   step_out;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem, fix_val;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc_q),
        .operand (operand_q),
        .acc_out (step_out)
    );

    // Operand magnitudes at acceptance time
    always_comb begin
        a_neg = op_a_signed(op) & a[XLEN-1];
        b_neg = op_b_signed(op) & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Sign correction and half/quotient/remainder selection
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val = quot;
            default:                     fix_val = rem;
        endcase
        if (special_q) begin
            fix_val = acc_q[XLEN-1:0];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        neg_d     = neg_q;
        special_d = special_q;
        count_d   = count_q;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d      = op;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    special_d = 1'b0;
                    // REM sign follows the dividend; everything else is the sign product
                    neg_d     = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
                    operand_d = op[2] ? b_mag : a_mag;
                    acc_d     = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
                    state_d   = CALC;
                    if (op[2] && b == '0) begin
                        special_d = 1'b1;
                        acc_d     = {{XLEN{1'b0}}, (op[1] ? a : ONES)};
                        state_d   = FIX;
                    end else if (op[2] && !op[0] && a == SMIN && b == ONES) begin
                        special_d = 1'b1;
                        acc_d     = {{XLEN{1'b0}}, (op[1] ? {XLEN{1'b0}} : a)};
                        state_d   = FIX;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = step_out;
                    if (count_q == CW'(XLEN - 1)) begin
                        state_d = FIX;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!kill) begin
                    result_d = fix_val;
                    done_d   = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            count_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            count_q   <= count_d;
            busy      <= busy_d;
            done      <= done_d;
            result    <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against
// a 64-bit arithmetic reference, and kill/reset/start-while-busy sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural RV32M result computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, ux, uy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            OP_MUL:    begin p = sx * sy; return p[31:0]; end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin up = 64'(ux) * 64'(uy); return up[63:32]; end
            OP_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            OP_DIVU: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            OP_REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        if (o == OP_DIV || o == OP_DIVU || o == OP_REM || o == OP_REMU) begin
            if (y == 0) return 1;
            if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return 1;
        end
        return 33;
    endfunction

    // Issue one op and follow it to done; optionally pulse a junk start mid-op,
    // and optionally return in the done cycle so the next start lands there.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat, input string name,
                          input bit noise, input bit chain);
        int lat;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise && lat == 5) begin
                start = 1'b1; op = OP_MULHU; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " busy during op"}, 64'(busy_ok), 64'd1);
        check({name, " busy at done"}, 64'(busy), 64'd0);
        if (!chain) begin
            @(posedge clk); #1;
            check({name, " done pulse width"}, 64'(done), 64'd0);
            check({name, " result hold"}, 64'(result), 64'(exp));
        end
    endtask

    initial begin
        int done_cnt;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{OP_DIVU,   32'd100,        32'd7,         32'd14,        33});
        vecs.push_back('{OP_REMU,   32'd100,        32'd7,         32'd2,         33});
        vecs.push_back('{OP_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REM,    32'h1234_5678,  32'd0,         32'h1234_5678, 1});
        vecs.push_back('{OP_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678, 1});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{OP_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{OP_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33});
        vecs.push_back('{OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i), 1'b0, 1'b0);
        end

        // Start issued in the done cycle is accepted
        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, "chain first", 1'b0, 1'b1);
        run_op(OP_REMU, 32'd1000, 32'd3, 32'd1, 33, "chain second", 1'b0, 1'b0);

        // Start pulses while busy must not disturb the running op
        run_op(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 33, "start while busy", 1'b1, 1'b0);

        // Kill mid-CALC: no done, result keeps its previous value
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "pre-kill", 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd999; b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill calc busy", 64'(busy), 64'd0);
        check("kill calc done", 64'(done), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("kill calc no done", 64'(done_cnt), 64'd0);
        check("kill calc result hold", 64'(result), 64'd14);
        run_op(OP_DIVU, 32'd999, 32'd10, 32'd99, 33, "post-kill", 1'b0, 1'b0);

        // Kill while in FIX (divide-by-zero goes straight there)
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill fix done", 64'(done), 64'd0);
        check("kill fix busy", 64'(busy), 64'd0);
        check("kill fix result hold", 64'(result), 64'd99);

        // Kill and start together in IDLE: start is dropped
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("kill+start done", 64'(done), 64'd0);
        check("kill+start result", 64'(result), 64'd99);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd21; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 33, "post-reset", 1'b0, 1'b0);

        // Randomised ops against the arithmetic reference, biased toward corners
        for (int i = 0; i < 200; i++) begin
            int sel;
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 255));
            run_op(ro, ra, rb, ref_model(ro, ra, rb), ref_latency(ro, ra, rb),
                   $sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
